digit_scan_receiver: RTL and testbench

DIGIT_SCAN_RECEIVER -- requirements
Module: digit_scan_receiver

---
 rtl/digit_scan_receiver_pkg.sv | 13 +
 rtl/digit_scan_receiver_if.sv | 16 +
 rtl/digit_scan_receiver_decode.sv | 23 ++
 rtl/digit_scan_receiver.sv | 128 ++++++++++++
 tb/tb_digit_scan_receiver.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/digit_scan_receiver_pkg.sv
// Shared constants and types for the multiplexed 4-digit scan receiver.
package digit_scan_receiver_pkg;
   localparam logic [3:0] SEL_D0    = 4'b1110;
   localparam logic [3:0] SEL_D1    = 4'b1101;
   localparam logic [3:0] SEL_D2    = 4'b1011;
   localparam logic [3:0] SEL_D3    = 4'b0111;
   localparam logic [3:0] SEL_BLANK = 4'b1111;

   // Idle counter width; holds TIMEOUT values up to 255.
   localparam int TO_W = 8;

   typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_e;
endpackage

// File: rtl/digit_scan_receiver_if.sv
// Scan-side inputs and captured-frame outputs of the receiver.
interface digit_scan_receiver_if;
   logic [3:0]  digit_select;
   logic [3:0]  digit_in;
   logic [15:0] value;
   logic        value_valid;
   logic        frame_done;
   logic        value_changed;
   logic        sel_error;
   logic        timeout_error;

   modport master (output digit_select, digit_in,
                   input  value, value_valid, frame_done, value_changed, sel_error, timeout_error);
   modport slave  (input  digit_select, digit_in,
                   output value, value_valid, frame_done, value_changed, sel_error, timeout_error);
endinterface

// File: rtl/digit_scan_receiver_decode.sv
// Maps an active-low one-hot digit strobe to {legal, blank, index}.
module digit_sel_decode
   import digit_scan_receiver_pkg::*;
(
   input  logic [3:0] sel_i,
   output logic       legal_o,
   output logic       blank_o,
   output logic [1:0] index_o
);
   always_comb begin
      legal_o = 1'b1;
      blank_o = 1'b0;
      index_o = 2'd0;
      case (sel_i)
         SEL_D0:    index_o = 2'd0;
         SEL_D1:    index_o = 2'd1;
         SEL_D2:    index_o = 2'd2;
         SEL_D3:    index_o = 2'd3;
         SEL_BLANK: blank_o = 1'b1;
         default:   legal_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/digit_scan_receiver.sv
// Reassembles a scanned 4-digit display into a 16-bit value with order and idle checking.
module digit_scan_receiver
   import digit_scan_receiver_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   digit_scan_receiver_if.slave bus
);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [3:0]      sel_q, din_q;
   logic            legal, blank;
   logic [1:0]      idx;
   state_e          state_q, state_d;
   logic [1:0]      exp_q, exp_d;
   logic [TO_W-1:0] idle_q, idle_d;
   logic [15:0]     shadow_q, shadow_d, value_q, value_d, new_val;
   logic            valid_q, valid_d, frame_q, frame_d, changed_q, changed_d;
   logic            selerr_q, selerr_d, toerr_q, toerr_d;

   digit_sel_decode u_dec (.sel_i(sel_q), .legal_o(legal), .blank_o(blank), .index_o(idx));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q     <= SEL_BLANK;
         din_q     <= 4'h0;
         state_q   <= HUNT;
         exp_q     <= 2'd0;
         idle_q    <= '0;
         shadow_q  <= 16'h0;
         value_q   <= 16'h0;
         valid_q   <= 1'b0;
         frame_q   <= 1'b0;
         changed_q <= 1'b0;
         selerr_q  <= 1'b0;
         toerr_q   <= 1'b0;
      end else begin
         sel_q     <= bus.digit_select;
         din_q     <= bus.digit_in;
         state_q   <= state_d;
         exp_q     <= exp_d;
         idle_q    <= idle_d;
         shadow_q  <= shadow_d;
         value_q   <= value_d;
         valid_q   <= valid_d;
         frame_q   <= frame_d;
         changed_q <= changed_d;
         selerr_q  <= selerr_d;
         toerr_q   <= toerr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      idle_d    = idle_q;
      shadow_d  = shadow_q;
      value_d   = value_q;
      valid_d   = valid_q;
      frame_d   = 1'b0;
      changed_d = 1'b0;
      selerr_d  = 1'b0;
      toerr_d   = 1'b0;
      new_val   = shadow_q;
      new_val[{idx, 2'b00} +: 4] = din_q;

      if (!legal) begin
         selerr_d = 1'b1;
         state_d  = HUNT;
         exp_d    = 2'd0;
         idle_d   = '0;
         shadow_d = 16'h0;
      end else if (blank) begin
         if (state_q == COLLECT) begin
            if (idle_q == TO_LAST) begin
               toerr_d = 1'b1;
               state_d = HUNT;
               exp_d   = 2'd0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + TO_W'(1);
            end
         end
      end else begin
         idle_d = '0;
         if (state_q == HUNT) begin
            if (idx == 2'd0) begin
               shadow_d = new_val;
               exp_d    = 2'd1;
               state_d  = COLLECT;
            end
         end else if (idx == exp_q) begin
            shadow_d = new_val;
            if (idx == 2'd3) begin
               value_d   = new_val;
               frame_d   = 1'b1;
               valid_d   = 1'b1;
               changed_d = (new_val != value_q);
               state_d   = HUNT;
               exp_d     = 2'd0;
            end else begin
               exp_d = exp_q + 2'd1;
            end
         // In COLLECT the last stored index is always expected-1; a held digit just overwrites it.
         end else if (idx == exp_q - 2'd1) begin
            shadow_d = new_val;
         end else begin
            selerr_d = 1'b1;
            if (idx == 2'd0) begin
               shadow_d = new_val;
               exp_d    = 2'd1;
            end else begin
               state_d = HUNT;
               exp_d   = 2'd0;
            end
         end
      end
   end

   assign bus.value         = value_q;
   assign bus.value_valid   = valid_q;
   assign bus.frame_done    = frame_q;
   assign bus.value_changed = changed_q;
   assign bus.sel_error     = selerr_q;
   assign bus.timeout_error = toerr_q;
endmodule

// File: tb/tb_digit_scan_receiver.sv
// Directed bench for digit_scan_receiver with hand-computed expectations.
module tb_digit_scan_receiver;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   n_frame = 0, n_chg = 0, n_sel = 0, n_to = 0, n_clash = 0;
   int   f0, c0, s0, t0;

   digit_scan_receiver_if bus ();
   digit_scan_receiver #(.TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Pulse tallies sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.frame_done)    n_frame++;
         if (bus.value_changed) n_chg++;
         if (bus.sel_error)     n_sel++;
         if (bus.timeout_error) n_to++;
         if (bus.frame_done && (bus.sel_error || bus.timeout_error)) n_clash++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Present one select/nibble pair for one cycle; returns #1 after the capturing edge.
   task automatic step(input logic [3:0] sel, input logic [3:0] din);
      bus.digit_select = sel;
      bus.digit_in     = din;
      @(posedge clk);
      #1;
   endtask

   task automatic blanks(input int n);
      for (int i = 0; i < n; i++) step(4'b1111, 4'h0);
   endtask

   task automatic snap();
      f0 = n_frame; c0 = n_chg; s0 = n_sel; t0 = n_to;
   endtask

   initial begin
      bus.digit_select = 4'b1111;
      bus.digit_in     = 4'h0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_value", {16'h0, bus.value}, 32'h0);
      chk("rst_valid", {31'h0, bus.value_valid}, 32'h0);
      chk("rst_pulses", {28'h0, bus.frame_done, bus.value_changed, bus.sel_error, bus.timeout_error}, 32'h0);
      reset = 1'b0;
      blanks(2);

      // Single-cycle scan of BEEF: frame_done one edge after digit3 is registered.
      snap();
      step(4'b1110, 4'hF);
      step(4'b1101, 4'hE);
      step(4'b1011, 4'hE);
      step(4'b0111, 4'hB);
      chk("beef_no_early_done", {31'h0, bus.frame_done}, 32'h0);
      chk("beef_no_early_valid", {31'h0, bus.value_valid}, 32'h0);
      step(4'b1111, 4'h0);
      chk("beef_done", {31'h0, bus.frame_done}, 32'h1);
      chk("beef_changed", {31'h0, bus.value_changed}, 32'h1);
      chk("beef_value", {16'h0, bus.value}, 32'hBEEF);
      chk("beef_valid", {31'h0, bus.value_valid}, 32'h1);
      step(4'b1111, 4'h0);
      chk("beef_done_one_cycle", {31'h0, bus.frame_done}, 32'h0);
      chk("beef_sel_none", n_sel - s0, 0);

      // Each digit held three cycles; same value so no change pulse.
      snap();
      for (int i = 0; i < 3; i++) step(4'b1110, 4'hF);
      for (int i = 0; i < 3; i++) step(4'b1101, 4'hE);
      for (int i = 0; i < 3; i++) step(4'b1011, 4'hE);
      for (int i = 0; i < 3; i++) step(4'b0111, 4'hB);
      blanks(2);
      chk("hold_value", {16'h0, bus.value}, 32'hBEEF);
      chk("hold_frames", n_frame - f0, 1);
      chk("hold_sel_none", n_sel - s0, 0);
      chk("hold_no_change", n_chg - c0, 0);

      // Out-of-order digit0 restarts the frame.
      snap();
      step(4'b1110, 4'h1);
      step(4'b1101, 4'h2);
      step(4'b1110, 4'h7);
      step(4'b1101, 4'h8);
      step(4'b1011, 4'h9);
      step(4'b0111, 4'hA);
      blanks(2);
      chk("restart_sel", n_sel - s0, 1);
      chk("restart_value", {16'h0, bus.value}, 32'hA987);
      chk("restart_frames", n_frame - f0, 1);
      chk("restart_changed", n_chg - c0, 1);

      // Eight blanks mid-frame abort it exactly once.
      snap();
      step(4'b1110, 4'h1);
      step(4'b1101, 4'h2);
      blanks(10);
      chk("to_count", n_to - t0, 1);
      chk("to_value_kept", {16'h0, bus.value}, 32'hA987);
      chk("to_valid_kept", {31'h0, bus.value_valid}, 32'h1);
      chk("to_no_frame", n_frame - f0, 0);

      // Seven blanks is one short of the limit; the frame survives.
      snap();
      step(4'b1110, 4'h3);
      step(4'b1101, 4'h4);
      blanks(7);
      step(4'b1011, 4'h5);
      step(4'b0111, 4'h6);
      blanks(2);
      chk("to_edge_none", n_to - t0, 0);
      chk("to_edge_value", {16'h0, bus.value}, 32'h6543);

      // Illegal select mid-frame, then a clean 1234 scan.
      snap();
      step(4'b1110, 4'h5);
      step(4'b1101, 4'h6);
      step(4'b1100, 4'h0);
      step(4'b1110, 4'h4);
      step(4'b1101, 4'h3);
      step(4'b1011, 4'h2);
      step(4'b0111, 4'h1);
      blanks(2);
      chk("illegal_sel", n_sel - s0, 1);
      chk("illegal_value", {16'h0, bus.value}, 32'h1234);

      // Skipping ahead from digit0 to digit2 drops to HUNT; a stray digit3 is then ignored.
      snap();
      step(4'b1110, 4'h1);
      step(4'b1011, 4'h2);
      step(4'b0111, 4'h3);
      blanks(2);
      chk("skip_sel", n_sel - s0, 1);
      chk("skip_no_frame", n_frame - f0, 0);
      chk("skip_value", {16'h0, bus.value}, 32'h1234);

      // Reset after digit2; a lone digit3 afterwards must not capture.
      step(4'b1110, 4'hF);
      step(4'b1101, 4'hE);
      step(4'b1011, 4'hE);
      bus.digit_select = 4'b1111;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_value", {16'h0, bus.value}, 32'h0);
      chk("mid_rst_valid", {31'h0, bus.value_valid}, 32'h0);
      reset = 1'b0;
      snap();
      step(4'b0111, 4'hB);
      blanks(2);
      chk("mid_rst_no_frame", n_frame - f0, 0);
      chk("mid_rst_still_invalid", {31'h0, bus.value_valid}, 32'h0);
      step(4'b1110, 4'hF);
      step(4'b1101, 4'hE);
      step(4'b1011, 4'hE);
      step(4'b0111, 4'hB);
      chk("post_rst_valid_low", {31'h0, bus.value_valid}, 32'h0);
      step(4'b1111, 4'h0);
      chk("post_rst_done", {31'h0, bus.frame_done}, 32'h1);
      chk("post_rst_changed", {31'h0, bus.value_changed}, 32'h1);
      chk("post_rst_valid", {31'h0, bus.value_valid}, 32'h1);
      chk("post_rst_value", {16'h0, bus.value}, 32'hBEEF);
      blanks(2);

      chk("no_err_with_done", n_clash, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
